// File: rtl/approx_adder_tree_pkg.sv
// Shared sizing for the approximate adder tree and its LOA cells.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package approx_adder_tree_pkg;

  // Default operand width of the eight tree inputs.
  localparam int IN_W_DEF        = 8;
  // Three adder levels, each adding one bit of growth.
  localparam int OUT_W_DEF       = IN_W_DEF + 3;
  // Number of low bits OR-ed instead of added in every cell; 0 = exact.
  localparam int APPROX_BITS_DEF = 2;

endpackage

// File: rtl/approx_adder_tree_loa_adder.sv
// Lower-part-OR approximate adder: low K bits OR-ed, upper part added exactly.
// Latency: combinational.
// Backpressure: none, pure logic.
module loa_adder #(
  parameter int W = 8,
  parameter int K = 2
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] z,
  output logic [W:0]   sum
);

  generate
    if (K == 0) begin : g_exact
      // No approximated bits: ordinary full-width add.
      assign sum = {1'b0, x} + {1'b0, z};
    end else if (K >= W) begin : g_all_or
      // Whole operand approximated; only the carry from the top bit pair survives.
      assign sum[W-1:0] = x | z;
      assign sum[W]     = x[W-1] & z[W-1];
    end else begin : g_loa
      // Carry predicted from the most significant approximated bit pair.
      logic cin;
      assign cin        = x[K-1] & z[K-1];
      assign sum[K-1:0] = x[K-1:0] | z[K-1:0];
      assign sum[W:K]   = {1'b0, x[W-1:K]} + {1'b0, z[W-1:K]} + {{(W-K){1'b0}}, cin};
    end
  endgenerate

endmodule

// File: rtl/approx_adder_tree.sv
// Pipelined 8-input approximate (LOA) adder tree, one result per cycle.
// Latency: 3 clk edges from operand sample to y.
// Backpressure: none; operands are sampled every cycle.
module approx_adder_tree
  import approx_adder_tree_pkg::*;
#(
  parameter int IN_W        = IN_W_DEF,
  parameter int APPROX_BITS = APPROX_BITS_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IN_W-1:0] a,
  input  logic [IN_W-1:0] b,
  input  logic [IN_W-1:0] c,
  input  logic [IN_W-1:0] d,
  input  logic [IN_W-1:0] e,
  input  logic [IN_W-1:0] f,
  input  logic [IN_W-1:0] g,
  input  logic [IN_W-1:0] h,
  output logic [IN_W+2:0] y
);

  // Combinational cell outputs, one per tree node.
  logic [IN_W:0]   s0_sum, s1_sum, s2_sum, s3_sum;
  logic [IN_W+1:0] t0_sum, t1_sum;
  logic [IN_W+2:0] y_sum;

  // Pipeline registers and their next-state values.
  logic [IN_W:0]   s0_d, s1_d, s2_d, s3_d;
  logic [IN_W:0]   s0_q, s1_q, s2_q, s3_q;
  logic [IN_W+1:0] t0_d, t1_d;
  logic [IN_W+1:0] t0_q, t1_q;
  logic [IN_W+2:0] y_d, y_q;

  // Level 1: pairwise sums of the raw operands.
  loa_adder #(.W(IN_W), .K(APPROX_BITS)) u_s0 (.x(a), .z(b), .sum(s0_sum));
  loa_adder #(.W(IN_W), .K(APPROX_BITS)) u_s1 (.x(c), .z(d), .sum(s1_sum));
  loa_adder #(.W(IN_W), .K(APPROX_BITS)) u_s2 (.x(e), .z(f), .sum(s2_sum));
  loa_adder #(.W(IN_W), .K(APPROX_BITS)) u_s3 (.x(g), .z(h), .sum(s3_sum));

  // Level 2: sums of registered level-1 results.
  loa_adder #(.W(IN_W+1), .K(APPROX_BITS)) u_t0 (.x(s0_q), .z(s1_q), .sum(t0_sum));
  loa_adder #(.W(IN_W+1), .K(APPROX_BITS)) u_t1 (.x(s2_q), .z(s3_q), .sum(t1_sum));

  // Level 3: final sum of registered level-2 results.
  loa_adder #(.W(IN_W+2), .K(APPROX_BITS)) u_y (.x(t0_q), .z(t1_q), .sum(y_sum));

  // Next-state for every pipeline stage is simply the cell output feeding it.
  always_comb begin
    s0_d = s0_sum;
    s1_d = s1_sum;
    s2_d = s2_sum;
    s3_d = s3_sum;
    t0_d = t0_sum;
    t1_d = t1_sum;
    y_d  = y_sum;
  end

  // Stage registers; reset clears every in-flight partial sum at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s0_q <= '0;
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
      t0_q <= '0;
      t1_q <= '0;
      y_q  <= '0;
    end else begin
      s0_q <= s0_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
      t0_q <= t0_d;
      t1_q <= t1_d;
      y_q  <= y_d;
    end
  end

  assign y = y_q;

endmodule

// File: tb/tb_approx_adder_tree.sv
// Scoreboard bench: exact (K=0) and approximate (K=2) trees side by side.
// Latency: expects results 3 edges after each sampled vector.
// Backpressure: none.
module tb_approx_adder_tree;

  localparam int IN_W = 8;

  logic            clk;
  logic            rst;
  logic [IN_W-1:0] a, b, c, d, e, f, g, h;
  logic [IN_W+2:0] y_ex, y_ap;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 0;
  int q_ex[$];
  int q_ap[$];
  int vec[8];

  approx_adder_tree #(.IN_W(IN_W), .APPROX_BITS(0)) u_exact (
    .clk(clk), .rst(rst),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
    .y(y_ex)
  );

  approx_adder_tree #(.IN_W(IN_W), .APPROX_BITS(2)) u_approx (
    .clk(clk), .rst(rst),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
    .y(y_ap)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Reference LOA addition in plain integer arithmetic.
  function automatic int loa_ref(int x, int z, int k);
    int m, low, carry;
    m     = (1 << k) - 1;
    low   = (x & m) | (z & m);
    carry = (k > 0) ? (((x >> (k - 1)) & (z >> (k - 1))) & 1) : 0;
    return (((x >> k) + (z >> k) + carry) << k) | low;
  endfunction

  function automatic int tree_ref(int v[8], int k);
    int s[4];
    int t0, t1;
    for (int i = 0; i < 4; i++) s[i] = loa_ref(v[2*i], v[2*i+1], k);
    t0 = loa_ref(s[0], s[1], k);
    t1 = loa_ref(s[2], s[3], k);
    return loa_ref(t0, t1, k);
  endfunction

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_vec();
    a = vec[0][IN_W-1:0]; b = vec[1][IN_W-1:0];
    c = vec[2][IN_W-1:0]; d = vec[3][IN_W-1:0];
    e = vec[4][IN_W-1:0]; f = vec[5][IN_W-1:0];
    g = vec[6][IN_W-1:0]; h = vec[7][IN_W-1:0];
  endtask

  // Drive the vector and queue explicitly given expectations.
  task automatic apply_exp(int e_ex, int e_ap);
    drive_vec();
    q_ex.push_back(e_ex);
    q_ap.push_back(e_ap);
  endtask

  // Drive the vector and queue expectations from the reference model.
  task automatic apply_model();
    int total;
    total = 0;
    for (int i = 0; i < 8; i++) total += vec[i];
    apply_exp(total, tree_ref(vec, 2));
  endtask

  task automatic set_all(int v);
    for (int i = 0; i < 8; i++) vec[i] = v;
  endtask

  task automatic set_ramp();
    for (int i = 0; i < 8; i++) vec[i] = i + 1;
  endtask

  // Release reset at a falling edge; two zero results precede the first real one.
  task automatic release_rst();
    rst = 1;
    q_ex.delete();
    q_ap.delete();
    repeat (2) begin
      q_ex.push_back(0);
      q_ap.push_back(0);
    end
    mon_en = 1;
  endtask

  // Monitor: one result per cycle, compared against the queue head.
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (q_ex.size() == 0 || q_ap.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_empty: got no expectation, expected one queued at %0t", $time);
      end else begin
        check("y_exact", int'(y_ex), q_ex.pop_front());
        check("y_approx", int'(y_ap), q_ap.pop_front());
      end
    end
  end

  initial begin
    rst = 0;
    set_all(0);
    drive_vec();
    #1;
    check("reset_y_exact", int'(y_ex), 0);
    check("reset_y_approx", int'(y_ap), 0);

    // Reset held with live operands: output must stay cleared.
    @(negedge clk);
    set_ramp();
    drive_vec();
    repeat (4) begin
      @(posedge clk);
      #1;
      check("held_reset_exact", int'(y_ex), 0);
      check("held_reset_approx", int'(y_ap), 0);
    end

    // Directed: ramp, then zeros, then saturation, then zeros.
    @(negedge clk);
    release_rst();
    set_ramp();
    apply_exp(36, 39);
    @(negedge clk);
    set_all(0);
    apply_exp(0, 0);
    @(negedge clk);
    set_all(255);
    apply_exp(2040, 2047);
    @(negedge clk);
    set_all(0);
    apply_exp(0, 0);

    // Random vectors, with an asynchronous reset dropped in midway.
    for (int i = 0; i < 1000; i++) begin
      if (i == 500) begin
        @(posedge clk);
        #2;
        mon_en = 0;
        rst = 0;
        #1;
        check("async_reset_exact", int'(y_ex), 0);
        check("async_reset_approx", int'(y_ap), 0);
        q_ex.delete();
        q_ap.delete();
        repeat (2) begin
          @(negedge clk);
          set_ramp();
          drive_vec();
          @(posedge clk);
          #1;
          check("reset_mid_held_exact", int'(y_ex), 0);
          check("reset_mid_held_approx", int'(y_ap), 0);
        end
        @(negedge clk);
        release_rst();
        set_ramp();
        apply_exp(36, 39);
      end
      @(negedge clk);
      for (int j = 0; j < 8; j++) vec[j] = int'($urandom_range(0, 255));
      apply_model();
    end

    // Drain the pipeline with zero vectors.
    repeat (4) begin
      @(negedge clk);
      set_all(0);
      apply_exp(0, 0);
    end
    @(posedge clk);
    #2;
    mon_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/approx_adder_tree.md
Name: approx_adder_tree

Overview:
- Pipelined 8-input, 8-bit unsigned adder tree producing an 11-bit sum.
- Built from lower-part-OR approximate adders (LOA): the low APPROX_BITS of each addition are OR-ed rather than added.
- Used as a low-power accumulation stage in the approximate-computing datapath; APPROX_BITS=0 gives an exact tree.

Parameters:
- IN_W, 8, width of each operand.
- APPROX_BITS, 2, number of LSBs approximated in every adder of the tree; legal range 0..IN_W.

Ports:
- clk  input  1  single system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0); port name kept as rst per codebase.
- a, b, c, d, e, f, g, h  input  IN_W each  unsigned operands, sampled every cycle.
- y  output  IN_W+3  registered tree sum.

Behaviour:
- Adder cell (LOA, operand width W, result W+1, K = APPROX_BITS):
  - sum[K-1:0] = x[K-1:0] | z[K-1:0].
  - Carry into the upper part = x[K-1] & z[K-1].
  - sum[W:K] = x[W-1:K] + z[W-1:K] + carry.
  - K=0 gives an exact add.
- Stage 1, registered: s0=a+b, s1=c+d, s2=e+f, s3=g+h; each 9 bits.
- Stage 2, registered: t0=s0+s1, t1=s2+s3; each 10 bits.
- Stage 3, registered: y=t0+t1; 11 bits.
- Latency is 3 rising clk edges from input sample to y. Throughput is one result per cycle, fully pipelined. No handshake.
- Inputs are not registered before stage 1.
- Widths: each level grows by one bit. No overflow or wrap for any input, including all 0xFF (LOA max 511 per pair still fits).
- Reset, rst=0:
  - All pipeline registers and y clear to 0 immediately, without waiting for clk.
  - Reset held: y stays 0 regardless of inputs.
  - On release, first valid y appears 3 edges later. Intermediate y values during the fill are computed from zeroed stages and are deterministic.
- Reset mid-operation discards all in-flight sums. No partial results survive.
- No state machine. Purely arithmetic pipeline.

Decomposition:
- Shared package: IN_W default, OUT_W = IN_W+3, APPROX_BITS default.
- One sub-module, loa_adder:
  - Parameters W, K.
  - Combinational, operands W bits, result W+1 bits.
  - Instantiated 7 times.
  - Top holds only pipeline registers.

Test Plan:
- Reset: drive inputs 1..8, hold rst=0 → y=0 throughout. Assert rst=0 mid-stream → y=0 asynchronously, before the next clk edge.
- Approximate sum, APPROX_BITS=2: a..h = 1,2,3,4,5,6,7,8 → after 3 edges y=39.
  - Stage 1 values: s=3,7,11,15.
  - Stage 2 values: t=11,27.
- Exact mode, APPROX_BITS=0: same inputs → y=36. All-0xFF inputs → y=2040.
- Pipelining: apply vector 1..8 then all zeros on consecutive cycles (APPROX_BITS=2) → y=39 for exactly one cycle, then 0 the next cycle.
- Max value, APPROX_BITS=2: all inputs 0xFF → y=2047 (511, 1023, 2047 per level), no wrap.
- Random: 1000 random vectors versus a bit-accurate LOA reference model (both APPROX_BITS=0 and 2) → y matches with 3-cycle delay. Exact mode matches the arithmetic sum.
